// File: rtl/mem_arb_pkg.sv
// Shared types for the bmem line-port arbiters: owner/state encodings, request payload, line-address helper.
package mem_arb_pkg;

    localparam int unsigned LINE_OFF_W = 5;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LINE_W     = 256;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_I    = 2'd2,
        OWN_PF   = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              read;
        logic              write;
        logic [LINE_W-1:0] wdata;
    } mem_req_t;

    // Clears the byte-in-line offset so the adapter always sees a line-aligned address.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'((1 << LINE_OFF_W) - 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority select: starved icache, then dcache, then icache, then prefetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   d_req,
    input  logic   i_req,
    input  logic   pf_req,
    input  logic   starved,
    output owner_t pick_c
);

    always_comb begin
        pick_c = OWN_NONE;
        if (starved && i_req) begin
            pick_c = OWN_I;
        end else if (d_req) begin
            pick_c = OWN_D;
        end else if (i_req) begin
            pick_c = OWN_I;
        end else if (pf_req) begin
            pick_c = OWN_PF;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares the single line-wide bmem adapter port among dcache, icache and prefetcher, one line in flight.
// Optional MEM_ARB_PF_MERGE_EN folds an icache read into an in-flight prefetch of the same line.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              icache_read,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic [ADDR_W-1:0] pf_addr,
    input  logic              pf_read,
    output logic [LINE_W-1:0] pf_rdata,
    output logic              pf_resp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [1:0]        owner
);

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    owner_t           pick_c;
    mem_req_t         req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             merge_q, merge_d;
    logic             merge_now_c, starved_c, done_c;

    assign starved_c = (cnt_q == CNT_W'(STARVE_LIMIT));
    assign done_c    = (state_q == BUSY) && mem_resp;

    mem_arb_pick u_pick (
        .d_req   (dcache_read | dcache_write),
        .i_req   (icache_read),
        .pf_req  (pf_read),
        .starved (starved_c),
        .pick_c  (pick_c)
    );

`ifdef MEM_ARB_PF_MERGE_EN
    assign merge_now_c = (state_q == BUSY) && (owner_q == OWN_PF) && icache_read
                         && (line_addr(icache_addr) == req_q.addr);
`else
    assign merge_now_c = 1'b0;
`endif

    // Completion is routed only to the owner (and to a merged icache).
    always_comb begin
        dcache_resp  = done_c && (owner_q == OWN_D);
        icache_resp  = done_c && ((owner_q == OWN_I) || merge_q || merge_now_c);
        pf_resp      = done_c && (owner_q == OWN_PF);
        dcache_rdata = dcache_resp ? mem_rdata : '0;
        icache_rdata = icache_resp ? mem_rdata : '0;
        pf_rdata     = pf_resp     ? mem_rdata : '0;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        merge_d = merge_q;
        unique case (state_q)
            IDLE: begin
                if (pick_c != OWN_NONE) begin
                    state_d = BUSY;
                    owner_d = pick_c;
                end
                unique case (pick_c)
                    OWN_D: begin
                        req_d.addr  = line_addr(dcache_addr);
                        req_d.write = dcache_write;
                        req_d.read  = ~dcache_write;
                        req_d.wdata = dcache_wdata;
                        if (icache_read && !starved_c) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    OWN_I: begin
                        req_d.addr  = line_addr(icache_addr);
                        req_d.read  = 1'b1;
                        req_d.write = 1'b0;
                        req_d.wdata = '0;
                        cnt_d       = '0;
                    end
                    OWN_PF: begin
                        req_d.addr  = line_addr(pf_addr);
                        req_d.read  = 1'b1;
                        req_d.write = 1'b0;
                        req_d.wdata = '0;
                    end
                    default: ;
                endcase
            end
            BUSY: begin
                merge_d = merge_q | merge_now_c;
                if (merge_now_c) begin
                    cnt_d = '0;
                end
                if (mem_resp) begin
                    req_d.read  = 1'b0;
                    req_d.write = 1'b0;
                    owner_d     = OWN_NONE;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                merge_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            req_q   <= '0;
            cnt_q   <= '0;
            merge_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            merge_q <= merge_d;
        end
    end

    assign mem_addr  = req_q.addr;
    assign mem_read  = req_q.read;
    assign mem_write = req_q.write;
    assign mem_wdata = req_q.wdata;
    assign owner     = owner_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(dcache_read && dcache_write))
                else $error("dcache_read and dcache_write asserted together");
            assert (!(mem_resp && (state_q != BUSY)))
                else $error("mem_resp received with no transaction outstanding");
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed vector table, corner sequences, random traffic vs a transaction model.
module tb_mem_req_arbiter;

`ifdef MEM_ARB_PF_MERGE_EN
    localparam bit MERGE_EN = 1'b1;
`else
    localparam bit MERGE_EN = 1'b0;
`endif
    localparam int LIMIT = 4;
    localparam logic [255:0] RD = {8{32'hA5C3_0F1E}};
    localparam logic [255:0] WD = {8{32'h1234_5678}};

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dcache_addr, icache_addr, pf_addr, mem_addr;
    logic         dcache_read, dcache_write, icache_read, pf_read;
    logic [255:0] dcache_wdata, dcache_rdata, icache_rdata, pf_rdata, mem_wdata, mem_rdata;
    logic         dcache_resp, icache_resp, pf_resp, mem_read, mem_write, mem_resp;
    logic [1:0]   owner;

    mem_req_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .dcache_addr(dcache_addr), .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_wdata(dcache_wdata), .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .icache_addr(icache_addr), .icache_read(icache_read), .icache_rdata(icache_rdata),
        .icache_resp(icache_resp),
        .pf_addr(pf_addr), .pf_read(pf_read), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .owner(owner)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level reference: who holds the port, what line, and arbitration history.
    int           m_owner;      // 0 none, 1 D, 2 I, 3 PF; nonzero while a line is outstanding
    bit           m_drain, m_merged;
    int           m_starve;
    logic [31:0]  m_addr;
    bit           m_wr;
    logic [255:0] m_wdata;
    bit           e_d, e_i, e_p;
    int           ad_wait, ad_fixed = -1;
    int           n_rise, n_both;
    bit           prev_busy;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return {a[31:5], 5'b00000};
    endfunction

    task automatic model_reset();
        m_owner = 0; m_drain = 0; m_merged = 0; m_starve = 0;
        m_addr = '0; m_wr = 0; m_wdata = '0; ad_wait = 0;
    endtask

    task automatic model_edge();
        bit req [1:3];
        int w;
        if (m_owner != 0) begin
            if (MERGE_EN && m_owner == 3 && icache_read && line_of(icache_addr) == m_addr) begin
                m_merged = 1; m_starve = 0;
            end
            if (mem_resp) begin m_owner = 0; m_drain = 1; end
        end else if (m_drain) begin
            m_drain = 0; m_merged = 0;
        end else begin
            req[1] = dcache_read | dcache_write; req[2] = icache_read; req[3] = pf_read;
            w = 0;
            if (m_starve == LIMIT && icache_read) w = 2;
            else for (int k = 1; k <= 3; k++) if (req[k] && w == 0) w = k;
            if (w == 1 && icache_read) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            if (w == 2) m_starve = 0;
            if (w != 0) begin
                m_owner = w;
                m_wr    = (w == 1) && dcache_write;
                m_wdata = (w == 1) ? dcache_wdata : '0;
                m_addr  = line_of(w == 1 ? dcache_addr : (w == 2 ? icache_addr : pf_addr));
            end
        end
    endtask

    task automatic compare_model();
        bit busy, hit, mrg;
        busy = (m_owner != 0);
        hit  = busy && mem_resp;
        mrg  = MERGE_EN && m_owner == 3 && icache_read && (line_of(icache_addr) == m_addr);
        e_d  = hit && m_owner == 1;
        e_i  = hit && (m_owner == 2 || (m_owner == 3 && (m_merged || mrg)));
        e_p  = hit && m_owner == 3;
        chk("mem_read", mem_read, busy && !m_wr);
        chk("mem_write", mem_write, busy && m_wr);
        chk("owner", owner, busy ? 2'(m_owner) : 2'd0);
        chk("mem_addr", mem_addr, m_addr);
        if (busy && m_wr) chk("mem_wdata", mem_wdata, m_wdata);
        chk("resps", {dcache_resp, icache_resp, pf_resp}, {e_d, e_i, e_p});
        chk("dcache_rdata", dcache_rdata, e_d ? mem_rdata : '0);
        chk("icache_rdata", icache_rdata, e_i ? mem_rdata : '0);
        chk("pf_rdata", pf_rdata, e_p ? mem_rdata : '0);
        if ((mem_read | mem_write) && !prev_busy) n_rise++;
        prev_busy = mem_read | mem_write;
        if (icache_resp && pf_resp) n_both++;
    endtask

    // One clock of model-checked operation with a bench-side adapter; requesters drop after their response.
    task automatic run_cycle();
        bit was_busy, dd, di, dp;
        mem_resp = 1'b0;
        if (m_owner != 0) begin
            if (ad_wait == 0) begin mem_resp = 1'b1; mem_rdata = {8{$urandom}}; end
            else ad_wait--;
        end
        #1;
        compare_model();
        dd = e_d; di = e_i; dp = e_p;
        was_busy = (m_owner != 0);
        @(posedge clk);
        model_edge();
        #1;
        if (!was_busy && m_owner != 0) ad_wait = (ad_fixed >= 0) ? ad_fixed : int'($urandom_range(0, 4));
        if (dd) begin dcache_read = 0; dcache_write = 0; end
        if (di) icache_read = 0;
        if (dp) pf_read = 0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        dcache_read = 0; dcache_write = 0; icache_read = 0; pf_read = 0; mem_resp = 0;
        dcache_addr = '0; icache_addr = '0; pf_addr = '0; dcache_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst mem_read", mem_read, 1'b0);
        chk("rst mem_write", mem_write, 1'b0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, '0);
        chk("rst owner", owner, 2'd0);
        chk("rst resps", {dcache_resp, icache_resp, pf_resp}, 3'b000);
        chk("rst rdata", dcache_rdata | icache_rdata | pf_rdata, '0);
        rst = 1'b0;
        model_reset();
        prev_busy = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h0000_1000 + 32'($urandom_range(0, 3)) * 32'd32 + 32'($urandom_range(0, 31));
    endfunction

    typedef struct {
        logic        dr, dw, ir, pr, rs;
        logic        erd, ewr;
        logic [1:0]  eown;
        logic [31:0] eaddr;
        logic [2:0]  eresp;   // {dcache, icache, pf}
    } vec_t;
    vec_t tv[$];

    function automatic void add(input bit dr, dw, ir, pr, rs, erd, ewr, input logic [1:0] eown,
                                input logic [31:0] eaddr, input logic [2:0] eresp);
        vec_t v;
        v.dr = dr; v.dw = dw; v.ir = ir; v.pr = pr; v.rs = rs;
        v.erd = erd; v.ewr = ewr; v.eown = eown; v.eaddr = eaddr; v.eresp = eresp;
        tv.push_back(v);
    endfunction

    initial begin
        rst = 1'b1;
        // Single icache read to 0x1044, adapter answers 6 cycles after the request.
        add(0,0,1,0,0, 0,0,0, 32'h0,    3'b000);
        for (int k = 0; k < 5; k++) add(0,0,1,0,0, 1,0,2, 32'h1040, 3'b000);
        add(0,0,1,0,1, 1,0,2, 32'h1040, 3'b010);
        add(0,0,0,0,0, 0,0,0, 32'h1040, 3'b000);
        add(0,0,0,0,0, 0,0,0, 32'h1040, 3'b000);
        // dcache write and icache read together: write first, icache picked 2 cycles after dcache_resp.
        add(0,1,1,0,0, 0,0,0, 32'h1040, 3'b000);
        add(0,1,1,0,0, 0,1,1, 32'h2000, 3'b000);
        add(0,1,1,0,1, 0,1,1, 32'h2000, 3'b100);
        add(0,0,1,0,0, 0,0,0, 32'h2000, 3'b000);
        add(0,0,1,0,0, 0,0,0, 32'h2000, 3'b000);
        add(0,0,1,0,0, 1,0,2, 32'h1040, 3'b000);
        add(0,0,1,0,1, 1,0,2, 32'h1040, 3'b010);
        add(0,0,0,0,0, 0,0,0, 32'h1040, 3'b000);
        // Four dcache wins over a held icache read, then icache promoted, then dcache again.
        for (int k = 0; k < 4; k++) begin
            add(1,0,1,0,0, 0,0,0, (k == 0) ? 32'h1040 : 32'h2000, 3'b000);
            add(1,0,1,0,1, 1,0,1, 32'h2000, 3'b100);
            add(1,0,1,0,0, 0,0,0, 32'h2000, 3'b000);
        end
        add(1,0,1,0,0, 0,0,0, 32'h2000, 3'b000);
        add(1,0,1,0,1, 1,0,2, 32'h1040, 3'b010);
        add(1,0,1,0,0, 0,0,0, 32'h1040, 3'b000);
        add(1,0,1,0,0, 0,0,0, 32'h1040, 3'b000);
        add(1,0,1,0,1, 1,0,1, 32'h2000, 3'b100);
        add(0,0,0,0,0, 0,0,0, 32'h2000, 3'b000);
        // Lone prefetch.
        add(0,0,0,1,0, 0,0,0, 32'h2000, 3'b000);
        add(0,0,0,1,1, 1,0,3, 32'h3000, 3'b001);
        add(0,0,0,0,0, 0,0,0, 32'h3000, 3'b000);

        @(posedge clk);
        #1;
        reset_dut();
        dcache_addr = 32'h0000_2008; icache_addr = 32'h0000_1044; pf_addr = 32'h0000_3000;
        dcache_wdata = WD; mem_rdata = RD;
        for (int k = 0; k < tv.size(); k++) begin
            dcache_read = tv[k].dr; dcache_write = tv[k].dw; icache_read = tv[k].ir;
            pf_read = tv[k].pr; mem_resp = tv[k].rs;
            #1;
            chk($sformatf("v%0d mem_read", k), mem_read, tv[k].erd);
            chk($sformatf("v%0d mem_write", k), mem_write, tv[k].ewr);
            chk($sformatf("v%0d owner", k), owner, tv[k].eown);
            chk($sformatf("v%0d mem_addr", k), mem_addr, tv[k].eaddr);
            if (tv[k].ewr) chk($sformatf("v%0d mem_wdata", k), mem_wdata, WD);
            chk($sformatf("v%0d resps", k), {dcache_resp, icache_resp, pf_resp}, tv[k].eresp);
            chk($sformatf("v%0d dcache_rdata", k), dcache_rdata, tv[k].eresp[2] ? RD : '0);
            chk($sformatf("v%0d icache_rdata", k), icache_rdata, tv[k].eresp[1] ? RD : '0);
            chk($sformatf("v%0d pf_rdata", k), pf_rdata, tv[k].eresp[0] ? RD : '0);
            @(posedge clk);
            #1;
        end

        // Prefetch in flight, icache read joins on the same line.
        reset_dut();
        pf_addr = 32'h0000_1040; icache_addr = 32'h0000_1044; pf_read = 1; ad_fixed = 3;
        n_rise = 0; n_both = 0;
        for (int c = 0; c < 20; c++) begin
            if (m_owner == 3) icache_read = 1;
            run_cycle();
        end
        chk("pf_icache tx count", n_rise, MERGE_EN ? 1 : 2);
        chk("pf_icache joint resp", n_both, MERGE_EN ? 1 : 0);

        // Asynchronous reset while a dcache read is outstanding.
        reset_dut();
        ad_fixed = 20; dcache_addr = 32'h0000_5010; dcache_read = 1;
        run_cycle();
        run_cycle();
        chk("pre_rst mem_read", mem_read, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst mem_read", mem_read, 1'b0);
        chk("async_rst owner", owner, 2'd0);
        chk("async_rst mem_addr", mem_addr, 32'h0);
        chk("async_rst resps", {dcache_resp, icache_resp, pf_resp}, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        prev_busy = 0;
        run_cycle();
        chk("rearb owner", owner, 2'd1);
        chk("rearb mem_addr", mem_addr, 32'h0000_5000);
        for (int c = 0; c < 4; c++) run_cycle();

        // Random traffic against the model.
        reset_dut();
        ad_fixed = -1;
        for (int c = 0; c < 2500; c++) begin
            if (!(dcache_read | dcache_write) && $urandom_range(0, 3) == 0) begin
                dcache_addr = rand_addr(); dcache_wdata = {8{$urandom}};
                if ($urandom_range(0, 1) == 1) dcache_write = 1; else dcache_read = 1;
            end
            if (!icache_read && $urandom_range(0, 3) == 0) begin
                icache_addr = rand_addr(); icache_read = 1;
            end
            if (!pf_read && $urandom_range(0, 4) == 0) begin
                pf_addr = rand_addr(); pf_read = 1;
            end else if (pf_read && m_owner != 3 && $urandom_range(0, 7) == 0) begin
                pf_read = 0;
            end
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sequences the single line-wide port of the bmem cacheline adapter among three requesters: dcache (read/write), icache (read) and the next-line prefetcher (read).
- Fixed priority is dcache > icache > prefetch. A starvation counter promotes the icache.
- Exactly one 256-bit line transaction is outstanding downstream. Completion data and response are routed back to the owner only.

Parameters:
- STARVE_LIMIT, 4, number of consecutive dcache wins over a pending icache read before icache is promoted (legal range 1..15).
- CNT_W, 4, width of the starvation counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- dcache_addr  in  32  line address
- dcache_read  in  1  held until dcache_resp
- dcache_write  in  1  held until dcache_resp
- dcache_wdata  in  256  writeback line
- dcache_rdata  out  256  returned line
- dcache_resp  out  1  one-cycle completion
- icache_addr  in  32  line address
- icache_read  in  1  held until icache_resp
- icache_rdata  out  256  returned line
- icache_resp  out  1  one-cycle completion
- pf_addr  in  32  prefetch line address
- pf_read  in  1  held until pf_resp
- pf_rdata  out  256  returned line
- pf_resp  out  1  one-cycle completion
- mem_addr  out  32  to adapter, bits [4:0] forced 0
- mem_read  out  1  held until mem_resp
- mem_write  out  1  held until mem_resp
- mem_wdata  out  256  to adapter
- mem_rdata  in  256  from adapter
- mem_resp  in  1  one-cycle completion from adapter
- owner  out  2  current owner: 0 none, 1 D, 2 I, 3 PF (debug)

Behaviour:
- Reset (async, immediate): state IDLE, owner 0, starvation counter 0.
- Reset values of outputs: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, all *_resp=0, all *_rdata=0.
- A reset mid-transaction abandons it. No response is issued; the adapter shares the same rst.
- States are IDLE, BUSY, DRAIN.
- IDLE: arbitrate over the live requests. Pick order is icache if starved (counter==STARVE_LIMIT), else dcache, else icache, else pf.
  - On a pick, register addr (low 5 bits zeroed), opcode and wdata into mem_* and record owner.
  - Next state is BUSY. mem_read/mem_write rise the cycle after the request is first seen, giving 1 cycle of arbitration latency.
- BUSY: mem_* are held stable.
  - On mem_resp, pulse the owner's *_resp in the same cycle (combinational). The owner's *_rdata equals mem_rdata in that cycle; the other *_rdata are 0.
  - Also on mem_resp, deassert mem_read/mem_write at the next edge and move to DRAIN.
- DRAIN: exactly one cycle with no arbitration, so the completed requester can drop its request. Next state is IDLE.
  - Back-to-back transactions are therefore spaced by 2 cycles minimum: resp, then DRAIN, then IDLE pick.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when icache_read is pending in IDLE and dcache wins.
  - Clears when icache is granted.
  - Holds otherwise.
- dcache_read and dcache_write asserted together is illegal. The write wins, and a simulation-only assertion fires.
- The prefetch is never preempted once granted. A pf_read that drops before grant is simply not picked.
- mem_resp outside BUSY is ignored, and a simulation-only assertion fires.

Optional Feature:
- Macro: MEM_ARB_PF_MERGE_EN.
- Defined: while owner==PF in BUSY, an icache_read whose line address equals the in-flight pf address is merged.
  - Set a merge flag. On mem_resp, pulse both icache_resp and pf_resp, with icache_rdata=pf_rdata=mem_rdata.
  - Clear the starvation counter. The flag clears in DRAIN.
- Undefined: the icache waits and is arbitrated normally after DRAIN.

Decomposition:
- Package mem_arb_pkg holds:
  - owner_t enum (OWN_NONE, OWN_D, OWN_I, OWN_PF) and state_t enum (IDLE, BUSY, DRAIN).
  - Localparam LINE_OFF_W=5.
- One natural sub-module, mem_arb_pick: combinational priority select taking request bits plus the starved flag and producing owner_t. It is reused by later multi-port arbiters.

Test Plan:
- Single icache read to 0x0000_1044, adapter responds 6 cycles later.
  - mem_addr=0x0000_1040 and mem_read rise 1 cycle after request.
  - icache_resp pulses with the data; dcache_resp and pf_resp stay 0.
- dcache write and icache read asserted together.
  - dcache granted first (mem_write=1, mem_wdata matches).
  - icache issued 2 cycles after dcache_resp.
- dcache issues 4 back-to-back reads while icache_read is held (STARVE_LIMIT=4).
  - 5th arbitration grants icache even though dcache_read is present; counter returns to 0.
- pf_read only, then icache_read to the same line mid-flight.
  - With MEM_ARB_PF_MERGE_EN, one mem transaction occurs and both resps pulse in the same cycle with identical data.
  - Without it, two transactions occur.
- rst asserted asynchronously during BUSY.
  - mem_read, owner and all resps go to 0 immediately; after release the first request is re-arbitrated from IDLE.
